// File: rtl/reg_wb_queue.sv
// Write-back sequencer: buffers execute-stage results and drives the single register-file
// write port one word per cycle in FIFO order. It also flags RAW hazards for two decode sources.
module reg_wb_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16,
    parameter int HI_REG = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      reqValid,
    output logic                      reqReady,
    input  logic [ADDR_W-1:0]         reqAddr,
    input  logic [DATA_W-1:0]         reqData,
    input  logic                      reqDual,
    input  logic [DATA_W-1:0]         reqDataHi,
    output logic                      wr,
    output logic [ADDR_W-1:0]         wrAddr,
    output logic [DATA_W-1:0]         wrData,
    input  logic [ADDR_W-1:0]         chkAddrA,
    input  logic [ADDR_W-1:0]         chkAddrB,
    output logic                      hazardA,
    output logic                      hazardB,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] HI_ADDR   = ADDR_W'(HI_REG);
    localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRI  = 2'd1,
        HI   = 2'd2
    } state_t;

    state_t state;

    // Entry storage; every entry is visible to the hazard logic, so it stays in flops.
    logic [ADDR_W-1:0] entryAddr [DEPTH];
    logic [DATA_W-1:0] entryData [DEPTH];
    logic              entryDual [DEPTH];
    logic [DATA_W-1:0] entryHi   [DEPTH];

    logic [PTR_W-1:0]  rdPtr;
    logic [PTR_W-1:0]  wrPtr;
    logic [DATA_W-1:0] hiLatch;

    logic push;
    logic pop;
    logic notEmpty;

    assign notEmpty = (count != '0);
    assign reqReady = (count < DEPTH_CNT);
    assign push     = reqValid && reqReady;
    assign pop      = (state != HI) && notEmpty;

    always_ff @(posedge clk) begin
        if (push) begin
            entryAddr[wrPtr] <= reqAddr;
            entryData[wrPtr] <= reqData;
            entryDual[wrPtr] <= reqDual;
            entryHi[wrPtr]   <= reqDataHi;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Drain FSM: a dual entry spends one extra cycle in HI to issue the high word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            wr      <= 1'b0;
            wrAddr  <= '0;
            wrData  <= '0;
            hiLatch <= '0;
        end else begin
            case (state)
                HI: begin
                    wr     <= 1'b1;
                    wrAddr <= HI_ADDR;
                    wrData <= hiLatch;
                    state  <= PRI;
                end
                default: begin
                    if (notEmpty) begin
                        wr     <= 1'b1;
                        wrAddr <= entryAddr[rdPtr];
                        wrData <= entryData[rdPtr];
                        if (entryDual[rdPtr]) begin
                            hiLatch <= entryHi[rdPtr];
                            state   <= HI;
                        end else begin
                            state   <= PRI;
                        end
                    end else begin
                        wr    <= 1'b0;
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    // An entry is live when its distance from the read pointer is below the occupancy.
    logic [DEPTH-1:0] entryValid;
    logic [DEPTH-1:0] matchA;
    logic [DEPTH-1:0] matchB;
    logic [DEPTH-1:0] dualLive;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : gen_entry
            logic [PTR_W-1:0] offset;
            assign offset         = PTR_W'(gi) - rdPtr;
            assign entryValid[gi] = ({1'b0, offset} < count);
            assign matchA[gi]     = entryValid[gi] && (entryAddr[gi] == chkAddrA);
            assign matchB[gi]     = entryValid[gi] && (entryAddr[gi] == chkAddrB);
            assign dualLive[gi]   = entryValid[gi] && entryDual[gi];
        end
    endgenerate

    logic hiPending;
    assign hiPending = (|dualLive) || (state == HI);

    assign hazardA = (|matchA) || (hiPending && (chkAddrA == HI_ADDR)) || (wr && (wrAddr == chkAddrA));
    assign hazardB = (|matchB) || (hiPending && (chkAddrB == HI_ADDR)) || (wr && (wrAddr == chkAddrB));

endmodule

// File: tb/tb_reg_wb_queue.sv
// Bench for reg_wb_queue: queue-level reference model compared every cycle, directed scenarios
// pinned with literal expectations, then randomized traffic.
module tb_reg_wb_queue;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 16;
    localparam int HI_REG = 15;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 reqValid = 1'b0;
    logic                 reqReady;
    logic [ADDR_W-1:0]    reqAddr = '0;
    logic [DATA_W-1:0]    reqData = '0;
    logic                 reqDual = 1'b0;
    logic [DATA_W-1:0]    reqDataHi = '0;
    logic                 wr;
    logic [ADDR_W-1:0]    wrAddr;
    logic [DATA_W-1:0]    wrData;
    logic [ADDR_W-1:0]    chkAddrA = '0;
    logic [ADDR_W-1:0]    chkAddrB = '0;
    logic                 hazardA;
    logic                 hazardB;
    logic [$clog2(DEPTH):0] count;

    reg_wb_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .HI_REG(HI_REG)) dut (
        .clk(clk), .rst(rst),
        .reqValid(reqValid), .reqReady(reqReady), .reqAddr(reqAddr), .reqData(reqData),
        .reqDual(reqDual), .reqDataHi(reqDataHi),
        .wr(wr), .wrAddr(wrAddr), .wrData(wrData),
        .chkAddrA(chkAddrA), .chkAddrB(chkAddrB), .hazardA(hazardA), .hazardB(hazardB),
        .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        bit                dual;
        logic [DATA_W-1:0] hi;
    } req_t;

    // Reference model: pending requests, a pending high word, and the write port image.
    req_t              mQ[$];
    bit                mWr = 1'b0;
    bit                mHiPend = 1'b0;
    logic [ADDR_W-1:0] mAddr = '0;
    logic [DATA_W-1:0] mData = '0;
    logic [DATA_W-1:0] mHi = '0;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit mHaz(input logic [ADDR_W-1:0] c);
        bit h = 1'b0;
        foreach (mQ[i]) begin
            if (mQ[i].a == c) h = 1'b1;
            if (mQ[i].dual && c == ADDR_W'(HI_REG)) h = 1'b1;
        end
        if (mHiPend && c == ADDR_W'(HI_REG)) h = 1'b1;
        if (mWr && mAddr == c) h = 1'b1;
        return h;
    endfunction

    function automatic void modelReset();
        mQ.delete();
        mWr = 1'b0;
        mHiPend = 1'b0;
        mAddr = '0;
        mData = '0;
        mHi = '0;
    endfunction

    // One clock cycle: drive at the falling edge, compare, advance the model across the rising edge.
    task automatic step(input bit v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                        input bit du, input logic [DATA_W-1:0] hi,
                        input logic [ADDR_W-1:0] ca, input logic [ADDR_W-1:0] cb);
        req_t r;
        bit acc;
        reqValid = v; reqAddr = a; reqData = d; reqDual = du; reqDataHi = hi;
        chkAddrA = ca; chkAddrB = cb;
        #1;
        check("wr", int'(wr), int'(mWr));
        check("wrAddr", int'(wrAddr), int'(mAddr));
        check("wrData", int'(wrData), int'(mData));
        check("count", int'(count), mQ.size());
        check("reqReady", int'(reqReady), int'(mQ.size() < DEPTH));
        check("hazardA", int'(hazardA), int'(mHaz(ca)));
        check("hazardB", int'(hazardB), int'(mHaz(cb)));
        if (wr) $display("[TB] write R%0d <= %h", wrAddr, wrData);
        acc = v && (mQ.size() < DEPTH);
        if (mHiPend) begin
            mWr = 1'b1; mAddr = ADDR_W'(HI_REG); mData = mHi; mHiPend = 1'b0;
        end else if (mQ.size() > 0) begin
            r = mQ.pop_front();
            mWr = 1'b1; mAddr = r.a; mData = r.d;
            if (r.dual) begin
                mHiPend = 1'b1; mHi = r.hi;
            end
        end else begin
            mWr = 1'b0;
        end
        if (acc) begin
            r.a = a; r.d = d; r.dual = du; r.hi = hi;
            mQ.push_back(r);
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic [ADDR_W-1:0] ca, input logic [ADDR_W-1:0] cb);
        step(1'b0, '0, '0, 1'b0, '0, ca, cb);
    endtask

    task automatic drain();
        for (int i = 0; i < 24 && (mQ.size() > 0 || mHiPend || mWr); i++) idle(4'd0, 4'd0);
        check("drained", int'(mQ.size() > 0 || mHiPend || mWr), 0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int wrRun;
        int maxCnt;
        int n;
        modelReset();
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_wr", int'(wr), 0);
        check("rst_count", int'(count), 0);
        check("rst_ready", int'(reqReady), 1);
        check("rst_wrAddr", int'(wrAddr), 0);
        @(negedge clk);
        rst = 1'b0;

        // Single push
        step(1'b1, 4'd3, 16'hF033, 1'b0, 16'h0, 4'd3, 4'd0);
        check("single_count", int'(count), 1);
        check("single_hazA_queued", int'(hazardA), 1);
        check("single_wr_early", int'(wr), 0);
        idle(4'd3, 4'd0);
        check("single_wr", int'(wr), 1);
        check("single_wrAddr", int'(wrAddr), 3);
        check("single_wrData", int'(wrData), 16'hF033);
        check("single_hazA_inflight", int'(hazardA), 1);
        idle(4'd3, 4'd0);
        check("single_wr_done", int'(wr), 0);
        check("single_hazA_clear", int'(hazardA), 0);
        check("single_hold_data", int'(wrData), 16'hF033);

        // Dual push
        step(1'b1, 4'd2, 16'h0050, 1'b1, 16'h0001, 4'd0, 4'd15);
        check("dual_hazB_queued", int'(hazardB), 1);
        idle(4'd0, 4'd15);
        check("dual_pri_addr", int'(wrAddr), 2);
        check("dual_pri_data", int'(wrData), 16'h0050);
        check("dual_hazB_hi", int'(hazardB), 1);
        idle(4'd0, 4'd15);
        check("dual_hi_wr", int'(wr), 1);
        check("dual_hi_addr", int'(wrAddr), 15);
        check("dual_hi_data", int'(wrData), 16'h0001);
        check("dual_hazB_inflight", int'(hazardB), 1);
        idle(4'd0, 4'd15);
        check("dual_hazB_clear", int'(hazardB), 0);
        check("dual_wr_done", int'(wr), 0);

        // Dual to R15: primary first, high word last
        step(1'b1, 4'd15, 16'hAAAA, 1'b1, 16'h5555, 4'd15, 4'd1);
        idle(4'd15, 4'd1);
        check("r15_pri_addr", int'(wrAddr), 15);
        check("r15_pri_data", int'(wrData), 16'hAAAA);
        idle(4'd15, 4'd1);
        check("r15_hi_addr", int'(wrAddr), 15);
        check("r15_hi_data", int'(wrData), 16'h5555);
        drain();

        // Fill with dual requests until full, then offer one more
        n = 0;
        while (reqReady && n < 20) begin
            step(1'b1, 4'(n), 16'h1000 + 16'(n), 1'b1, 16'h2000 + 16'(n), 4'(n), 4'd15);
            n++;
        end
        check("fill_count", int'(count), 4);
        check("fill_ready", int'(reqReady), 0);
        step(1'b1, 4'hE, 16'hDEAD, 1'b0, 16'h0, 4'hE, 4'd15);
        drain();

        // Stream of eight single requests
        wrRun = 0;
        maxCnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (i < 8) step(1'b1, 4'(i + 4), 16'h3000 + 16'(i), 1'b0, 16'h0, 4'(i), 4'(i + 4));
            else       idle(4'd0, 4'd0);
            if (wr) wrRun++;
            if (int'(count) > maxCnt) maxCnt = int'(count);
        end
        check("stream_wr_cycles", wrRun, 8);
        check("stream_max_count", maxCnt, 1);
        drain();

        // Reset mid-traffic: three entries queued with a high word pending
        n = 0;
        while (!(mQ.size() >= 3 && mHiPend) && n < 30) begin
            step(1'b1, 4'(n + 1), 16'h4000 + 16'(n), 1'b1, 16'h5000 + 16'(n), 4'd15, 4'd1);
            n++;
        end
        check("pre_reset_state", int'(mQ.size() >= 3 && mHiPend), 1);
        reqValid = 1'b0;
        rst = 1'b1;
        #1;
        check("mid_rst_wr", int'(wr), 0);
        check("mid_rst_count", int'(count), 0);
        check("mid_rst_ready", int'(reqReady), 1);
        check("mid_rst_hazA", int'(hazardA), 0);
        check("mid_rst_hazB", int'(hazardB), 0);
        @(negedge clk);
        rst = 1'b0;
        modelReset();
        wrRun = 0;
        for (int i = 0; i < 5; i++) begin
            idle(4'd15, 4'd1);
            if (wr) wrRun++;
        end
        check("post_rst_no_writes", wrRun, 0);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            logic [ADDR_W-1:0] ca;
            logic [ADDR_W-1:0] cb;
            ca = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
            cb = 4'($urandom_range(0, 15));
            step($urandom_range(0, 99) < 60, 4'($urandom_range(0, 15)), 16'($urandom),
                 $urandom_range(0, 9) < 3, 16'($urandom), ca, cb);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
